// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core pipeline: register-file addressing
// and the hazard controller state encoding.
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } hctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// It sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block evaluation order.
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core. It handles the
// load-use interlock, multi-cycle redirect flush and dmem freeze.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int REDIRECT_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_write_en,
    output logic             exmem_write_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic ST_RUN   = logic'(RUN);
    localparam logic ST_REDIR = logic'(REDIR);

    // The redirect cycle itself is the first flush cycle, so REDIR covers
    // the remaining REDIRECT_CYCLES-1 cycles and rcnt counts them down to 0.
    localparam logic [2:0] REDIR_INIT =
        (REDIRECT_CYCLES > 1) ? 3'(REDIRECT_CYCLES - 2) : 3'd0;

    logic       state;
    logic       state_d;
    logic [2:0] rcnt;
    logic [2:0] rcnt_d;
    logic       load_use;
    logic       redirect_taken;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign load_use = ex_memRead && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        pc_write_en    = 1'b0;
        ifid_write_en  = 1'b0;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        idex_write_en  = 1'b0;
        exmem_write_en = 1'b0;
        redirect_taken = 1'b0;
        state_d        = state;
        rcnt_d         = rcnt;

        if (rst) begin
            state_d = ST_RUN;
            rcnt_d  = 3'd0;
        end else if (dmem_busy) begin
            // Whole pipe holds; EX keeps any redirecting instruction for later.
        end else if (ex_redirect) begin
            pc_write_en    = 1'b1;
            ifid_write_en  = 1'b1;
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
            idex_write_en  = 1'b1;
            exmem_write_en = 1'b1;
            redirect_taken = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
                state_d = ST_REDIR;
                rcnt_d  = REDIR_INIT;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state == ST_REDIR) begin
            // ID holds a flushed NOP here, so a load-use match is spurious.
            pc_write_en    = 1'b1;
            ifid_write_en  = 1'b1;
            ifid_flush     = 1'b1;
            idex_write_en  = 1'b1;
            exmem_write_en = 1'b1;
            if (rcnt == 3'd0) begin
                state_d = ST_RUN;
            end else begin
                rcnt_d = rcnt - 3'd1;
            end
        end else if (load_use) begin
            idex_bubble    = 1'b1;
            idex_write_en  = 1'b1;
            exmem_write_en = 1'b1;
        end else begin
            pc_write_en    = 1'b1;
            ifid_write_en  = 1'b1;
            idex_write_en  = 1'b1;
            exmem_write_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            rcnt  <= 3'd0;
        end else begin
            state <= state_d;
            rcnt  <= rcnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (!pc_write_en),
        .count (stall_q)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (redirect_taken),
        .count (flush_q)
    );

    // Counters read as zero while reset is held, like every other output.
    assign stall_cnt = rst ? '0 : stall_q;
    assign flush_cnt = rst ? '0 : flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with REDIRECT_CYCLES=3 and CNT_W=4.
// Expected control vectors are table constants; counters use a small model.
module tb_hazard_ctrl;

    localparam int RC = 3;
    localparam int CW = 4;

    // Control vector order: pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we
    localparam logic [5:0] C_RST  = 6'b000000;
    localparam logic [5:0] C_FRZ  = 6'b000000;
    localparam logic [5:0] C_NORM = 6'b110011;
    localparam logic [5:0] C_LU   = 6'b000111;
    localparam logic [5:0] C_EVT  = 6'b111111;
    localparam logic [5:0] C_RED  = 6'b111011;

    typedef struct {
        string          tag;
        logic [5:0]     ctrl;
        logic [CW-1:0]  stall;
        logic [CW-1:0]  flush;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          ex_memRead = 1'b0, ex_redirect = 1'b0;
    logic          dmem_busy = 1'b0, cnt_clr = 1'b0;
    logic          pc_write_en, ifid_write_en, ifid_flush;
    logic          idex_bubble, idex_write_en, exmem_write_en;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] m_stall  = '0;
    logic [CW-1:0] m_flush  = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REDIRECT_CYCLES(RC), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_memRead     (ex_memRead),
        .ex_redirect    (ex_redirect),
        .dmem_busy      (dmem_busy),
        .cnt_clr        (cnt_clr),
        .pc_write_en    (pc_write_en),
        .ifid_write_en  (ifid_write_en),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .idex_write_en  (idex_write_en),
        .exmem_write_en (exmem_write_en),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; dmem_busy = 1'b0; ex_redirect = 1'b0; cnt_clr = 1'b0;
        ex_memRead = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    // Inputs are already applied (just after a rising edge). Push the
    // expectation, compare on the falling edge, then advance the counter model.
    task automatic cycle(input string tag, input logic [5:0] ctrl);
        exp_t e;
        exp_t got;
        e.tag   = tag;
        e.ctrl  = ctrl;
        e.stall = rst ? '0 : m_stall;
        e.flush = rst ? '0 : m_flush;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check({got.tag, ".ctrl"},  32'({pc_write_en, ifid_write_en, ifid_flush,
                                       idex_bubble, idex_write_en, exmem_write_en}), 32'(got.ctrl));
        check({got.tag, ".stall"}, 32'(stall_cnt), 32'(got.stall));
        check({got.tag, ".flush"}, 32'(flush_cnt), 32'(got.flush));
        @(posedge clk);
        if (rst || cnt_clr) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!ctrl[5] && m_stall != '1) m_stall = m_stall + 1'b1;
            if (ex_redirect && !dmem_busy && m_flush != '1) m_flush = m_flush + 1'b1;
        end
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        cycle("reset", C_RST);

        set_idle();
        cycle("normal0", C_NORM);

        set_load_use();
        cycle("lu_stall", C_LU);
        ex_memRead = 1'b0;
        cycle("lu_after", C_NORM);

        set_idle(); ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        cycle("lu_x0", C_NORM);
        set_idle(); ex_memRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
        cycle("lu_unused_rs2", C_NORM);

        set_idle(); ex_redirect = 1'b1;
        cycle("redir_evt", C_EVT);
        ex_redirect = 1'b0;
        cycle("redir_c2", C_RED);
        cycle("redir_c3", C_RED);
        cycle("redir_done", C_NORM);

        ex_redirect = 1'b1;
        cycle("frz_evt", C_EVT);
        ex_redirect = 1'b0; dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) cycle("frz_hold", C_FRZ);
        dmem_busy = 1'b0;
        cycle("frz_c2", C_RED);
        cycle("frz_c3", C_RED);
        cycle("frz_done", C_NORM);

        set_load_use(); ex_redirect = 1'b1;
        cycle("redir_lu_evt", C_EVT);
        set_idle();
        cycle("redir_lu_c2", C_RED);
        cycle("redir_lu_c3", C_RED);
        cycle("redir_lu_done", C_NORM);

        dmem_busy = 1'b1; ex_redirect = 1'b1;
        cycle("busy_redir0", C_FRZ);
        cycle("busy_redir1", C_FRZ);
        dmem_busy = 1'b0;
        cycle("busy_redir_evt", C_EVT);
        ex_redirect = 1'b0;
        cycle("busy_redir_c2", C_RED);
        cycle("busy_redir_c3", C_RED);
        cycle("busy_redir_done", C_NORM);

        ex_redirect = 1'b1;
        cycle("redir_ign_evt", C_EVT);
        ex_redirect = 1'b0; set_load_use();
        cycle("redir_ign_c2", C_RED);
        cycle("redir_ign_c3", C_RED);
        cycle("redir_ign_lu", C_LU);
        set_idle();
        cycle("redir_ign_done", C_NORM);

        dmem_busy = 1'b1;
        for (int i = 0; i < 20; i++) cycle("sat_stall", C_FRZ);
        dmem_busy = 1'b0;
        cycle("sat_after", C_NORM);
        check("sat_value", 32'(stall_cnt), 32'd15);

        dmem_busy = 1'b1; cnt_clr = 1'b1;
        cycle("clr_stall", C_FRZ);
        set_idle();
        cycle("clr_after", C_NORM);
        check("clr_value", 32'(stall_cnt), 32'd0);

        ex_redirect = 1'b1;
        cycle("rst_mid_evt", C_EVT);
        ex_redirect = 1'b0; rst = 1'b1;
        cycle("rst_mid", C_RST);
        rst = 1'b0;
        cycle("rst_mid_after", C_NORM);
        cycle("rst_mid_run", C_NORM);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
